// File: rtl/spmv_phase_ctrl.sv
// spmv_phase_ctrl: scatter/gather phase sequencer for the SpMV pipeline.
// Walks all partitions through scatter, then through gather, once per
// iteration, admitting a fixed number of beats per partition and waiting
// for the pipeline to drain before moving to the next partition.
module spmv_phase_ctrl #(
  parameter int PIPE_DEPTH = 5,
  parameter int PAR_W      = 8,
  parameter int ITER_W     = 8,
  parameter int CNT_W      = 20,
  parameter int DRAIN_CYC  = PIPE_DEPTH + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PAR_W-1:0]  num_par,
  input  logic [ITER_W-1:0] num_iter,
  input  logic [CNT_W-1:0]  edge_cnt,
  input  logic [CNT_W-1:0]  upd_cnt,
  input  logic              edge_valid,
  output logic              edge_ready,
  input  logic              upd_valid,
  output logic              upd_ready,
  output logic [1:0]        control,
  output logic              pp_input_valid,
  output logic [PAR_W-1:0]  part_idx,
  output logic [ITER_W-1:0] iter_idx,
  output logic              busy,
  output logic              done
);

  localparam int DRN_W = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_LOAD  = 3'd1,
    SCATTER = 3'd2,
    S_DRAIN = 3'd3,
    G_LOAD  = 3'd4,
    GATHER  = 3'd5,
    G_DRAIN = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [DRN_W-1:0]    drn_q, drn_d;
  logic [PAR_W-1:0]    part_q, part_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [PAR_W-1:0]    npar_q, npar_d;
  logic [ITER_W-1:0]   niter_q, niter_d;
  logic [1:0]          control_q, control_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Partition finished (zero-count load or drain expired) this cycle.
  logic                adv;
  logic                in_gather;
  logic                more_par;
  logic                more_iter;

  assign more_par  = ((PAR_W+1)'(part_q) + (PAR_W+1)'(1)) < (PAR_W+1)'(npar_q);
  assign more_iter = ((ITER_W+1)'(iter_q) + (ITER_W+1)'(1)) < (ITER_W+1)'(niter_q);

  // State and datapath registers, cleared asynchronously so a reset aborts at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      drn_q     <= '0;
      part_q    <= '0;
      iter_q    <= '0;
      npar_q    <= '0;
      niter_q   <= '0;
      control_q <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      drn_q     <= drn_d;
      part_q    <= part_d;
      iter_q    <= iter_d;
      npar_q    <= npar_d;
      niter_q   <= niter_d;
      control_q <= control_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic, including the partition/phase/iteration advance step.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    drn_d     = drn_q;
    part_d    = part_q;
    iter_d    = iter_q;
    npar_d    = npar_q;
    niter_d   = niter_q;
    done_d    = 1'b0;
    adv       = 1'b0;
    in_gather = (state_q == G_LOAD) || (state_q == GATHER) || (state_q == G_DRAIN);

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((num_par != '0) && (num_iter != '0)) begin
            npar_d  = num_par;
            niter_d = num_iter;
            part_d  = '0;
            iter_d  = '0;
            state_d = S_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        rem_d = edge_cnt;
        if (edge_cnt == '0) adv = 1'b1;
        else                state_d = SCATTER;
      end
      SCATTER: begin
        if (edge_valid) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            drn_d   = DRN_W'(DRAIN_CYC);
            state_d = S_DRAIN;
          end
        end
      end
      G_LOAD: begin
        rem_d = upd_cnt;
        if (upd_cnt == '0) adv = 1'b1;
        else               state_d = GATHER;
      end
      GATHER: begin
        if (upd_valid) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            drn_d   = DRN_W'(DRAIN_CYC);
            state_d = G_DRAIN;
          end
        end
      end
      S_DRAIN, G_DRAIN: begin
        drn_d = drn_q - DRN_W'(1);
        if (drn_q == DRN_W'(1)) adv = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      if (more_par) begin
        part_d  = part_q + PAR_W'(1);
        state_d = in_gather ? G_LOAD : S_LOAD;
      end else if (!in_gather) begin
        part_d  = '0;
        state_d = G_LOAD;
      end else if (more_iter) begin
        iter_d  = iter_q + ITER_W'(1);
        part_d  = '0;
        state_d = S_LOAD;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    // Mode and busy are registered off the next state so they line up with it.
    case (state_d)
      S_LOAD, SCATTER, S_DRAIN: control_d = 2'd1;
      G_LOAD, GATHER, G_DRAIN:  control_d = 2'd2;
      default:                  control_d = 2'd0;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Output decode: ready comes straight from state so beats are taken same cycle.
  always_comb begin
    edge_ready     = (state_q == SCATTER);
    upd_ready      = (state_q == GATHER);
    pp_input_valid = (edge_valid & edge_ready) | (upd_valid & upd_ready);
    control        = control_q;
    part_idx       = part_q;
    iter_idx       = iter_q;
    busy           = busy_q;
    done           = done_q;
  end

endmodule

// File: tb/tb_spmv_phase_ctrl.sv
// Randomized bench for spmv_phase_ctrl with a timeline-building reference model.
module tb_spmv_phase_ctrl;

  localparam int PAR_W = 8;
  localparam int ITER_W = 8;
  localparam int CNT_W = 20;
  localparam int DRAIN = 7;
  localparam int LEN = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [PAR_W-1:0]  num_par = '0;
  logic [ITER_W-1:0] num_iter = '0;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  upd_cnt;
  logic              edge_valid = 1'b0;
  logic              edge_ready;
  logic              upd_valid = 1'b0;
  logic              upd_ready;
  logic [1:0]        control;
  logic              pp_input_valid;
  logic [PAR_W-1:0]  part_idx;
  logic [ITER_W-1:0] iter_idx;
  logic              busy;
  logic              done;

  logic [CNT_W-1:0] ecnt_tab [256];
  logic [CNT_W-1:0] ucnt_tab [256];
  assign edge_cnt = ecnt_tab[part_idx];
  assign upd_cnt  = ucnt_tab[part_idx];

  spmv_phase_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_par(num_par), .num_iter(num_iter),
    .edge_cnt(edge_cnt), .upd_cnt(upd_cnt), .edge_valid(edge_valid),
    .edge_ready(edge_ready), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .control(control), .pp_input_valid(pp_input_valid), .part_idx(part_idx),
    .iter_idx(iter_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  bit vpat_e [LEN];
  bit vpat_u [LEN];
  int exp_ctrl [LEN];
  int exp_part [LEN];
  int exp_iter [LEN];
  int exp_busy [LEN];
  int exp_done [LEN];
  int exp_er [LEN];
  int exp_ur [LEN];
  int exp_pv [LEN];
  int prev_part = 0;
  int prev_iter = 0;
  int run_no = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic gen_pat(input bit allv);
    for (int c = 0; c < LEN; c++) begin
      vpat_e[c] = (allv || c > 600) ? 1'b1 : 1'($urandom_range(0, 1));
      vpat_u[c] = (allv || c > 600) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 32'(control), 0);
    check({tag, "_er"}, 32'(edge_ready), 0);
    check({tag, "_ur"}, 32'(upd_ready), 0);
    check({tag, "_pv"}, 32'(pp_input_valid), 0);
    check({tag, "_part"}, 32'(part_idx), 0);
    check({tag, "_iter"}, 32'(iter_idx), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // Builds the expected cycle-by-cycle timeline from the phase rules, then
  // drives the DUT and compares every cycle. Cycle 0 is the start cycle.
  task automatic do_run(input int npar, input int niter, input bit ign,
                        input bit rst_in_drain, output int dut_done_c, output int edge_beats);
    int t, endc, ign_c, cnt, b, first_drain, rst_at;
    bit aborted;
    for (int c = 0; c < LEN; c++) begin
      exp_ctrl[c] = 0; exp_busy[c] = 0; exp_done[c] = 0;
      exp_er[c] = 0; exp_ur[c] = 0; exp_pv[c] = 0;
      exp_part[c] = prev_part; exp_iter[c] = prev_iter;
    end
    first_drain = -1;
    if (npar == 0 || niter == 0) begin
      endc = 1;
      exp_done[1] = 1;
    end else begin
      t = 1;
      for (int it = 0; it < niter; it++)
        for (int ph = 1; ph <= 2; ph++)
          for (int p = 0; p < npar; p++) begin
            cnt = (ph == 1) ? int'(ecnt_tab[p]) : int'(ucnt_tab[p]);
            exp_ctrl[t] = ph; exp_busy[t] = 1; exp_part[t] = p; exp_iter[t] = it;
            t++;
            if (cnt != 0) begin
              b = 0;
              while (b < cnt) begin
                exp_ctrl[t] = ph; exp_busy[t] = 1; exp_part[t] = p; exp_iter[t] = it;
                if (ph == 1) begin
                  exp_er[t] = 1;
                  if (vpat_e[t]) begin exp_pv[t] = 1; b++; end
                end else begin
                  exp_ur[t] = 1;
                  if (vpat_u[t]) begin exp_pv[t] = 1; b++; end
                end
                t++;
              end
              if (first_drain < 0) first_drain = t;
              for (int d = 0; d < DRAIN; d++) begin
                exp_ctrl[t] = ph; exp_busy[t] = 1; exp_part[t] = p; exp_iter[t] = it;
                t++;
              end
            end
          end
      endc = t;
      exp_done[t] = 1;
      for (int c = t; c < LEN; c++) begin
        exp_part[c] = npar - 1;
        exp_iter[c] = niter - 1;
      end
      prev_part = npar - 1;
      prev_iter = niter - 1;
    end
    ign_c  = (ign && endc >= 3) ? 2 + $urandom_range(0, endc - 3) : -1;
    rst_at = (rst_in_drain && first_drain > 0) ? first_drain + 2 : -1;

    dut_done_c = -1;
    edge_beats = 0;
    aborted = 1'b0;
    for (int c = 0; c <= endc + 1 && !aborted; c++) begin
      start      = (c == 0) || (c == ign_c);
      num_par    = (c == 0) ? PAR_W'(npar) : PAR_W'($urandom_range(1, 4));
      num_iter   = (c == 0) ? ITER_W'(niter) : ITER_W'($urandom_range(1, 4));
      edge_valid = vpat_e[c];
      upd_valid  = vpat_u[c];
      if (c == rst_at) begin
        check("pre_rst_ctrl", 32'(control), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_now");
        aborted = 1'b1;
      end else begin
        @(negedge clk);
        check($sformatf("r%0d c%0d ctrl", run_no, c), 32'(control), 32'(exp_ctrl[c]));
        check($sformatf("r%0d c%0d part", run_no, c), 32'(part_idx), 32'(exp_part[c]));
        check($sformatf("r%0d c%0d iter", run_no, c), 32'(iter_idx), 32'(exp_iter[c]));
        check($sformatf("r%0d c%0d busy", run_no, c), 32'(busy), 32'(exp_busy[c]));
        check($sformatf("r%0d c%0d done", run_no, c), 32'(done), 32'(exp_done[c]));
        check($sformatf("r%0d c%0d e_rdy", run_no, c), 32'(edge_ready), 32'(exp_er[c]));
        check($sformatf("r%0d c%0d u_rdy", run_no, c), 32'(upd_ready), 32'(exp_ur[c]));
        check($sformatf("r%0d c%0d pv", run_no, c), 32'(pp_input_valid), 32'(exp_pv[c]));
        if (done && dut_done_c < 0) dut_done_c = c;
        if (pp_input_valid && edge_ready) edge_beats++;
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    if (aborted) begin
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst_held");
      @(posedge clk);
      #1;
      rst = 1'b0;
      prev_part = 0;
      prev_iter = 0;
      @(negedge clk);
      check("rst_release_done", 32'(done), 0);
      @(posedge clk);
      #1;
    end
    $display("run %0d: num_par=%0d num_iter=%0d model_end=%0d dut_done=%0d edge_beats=%0d%s",
             run_no, npar, niter, endc, dut_done_c, edge_beats, aborted ? " (reset abort)" : "");
    run_no++;
  endtask

  initial begin
    int dc, eb, np, ni;
    for (int i = 0; i < 256; i++) begin ecnt_tab[i] = '0; ucnt_tab[i] = '0; end
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic run with always-valid streams.
    ecnt_tab[0] = 3; ucnt_tab[0] = 2;
    gen_pat(1'b1);
    do_run(1, 1, 1'b0, 1'b0, dc, eb);
    check("basic_done_cycle", 32'(dc), 22);
    check("basic_edge_beats", 32'(eb), 3);

    // Backpressure: edge_valid 1,0,1,0,1 from the first SCATTER cycle.
    ecnt_tab[0] = 3; ucnt_tab[0] = 0;
    gen_pat(1'b1);
    vpat_e[2] = 1'b1; vpat_e[3] = 1'b0; vpat_e[4] = 1'b1; vpat_e[5] = 1'b0; vpat_e[6] = 1'b1;
    do_run(1, 1, 1'b0, 1'b0, dc, eb);
    check("bp_edge_beats", 32'(eb), 3);

    // Multi partition / iteration, zero-count partition 1, start pulse mid-run.
    ecnt_tab[0] = 2; ecnt_tab[1] = 0; ecnt_tab[2] = 1;
    ucnt_tab[0] = 1; ucnt_tab[1] = 3; ucnt_tab[2] = 2;
    gen_pat(1'b0);
    do_run(3, 2, 1'b1, 1'b0, dc, eb);
    check("multi_edge_beats", 32'(eb), 6);

    // Zero num_par start: done next cycle, busy never high.
    do_run(0, 2, 1'b0, 1'b0, dc, eb);
    check("zero_par_done_cycle", 32'(dc), 1);

    // Reset during S_DRAIN, then a fresh run.
    ecnt_tab[0] = 2; ucnt_tab[0] = 2;
    gen_pat(1'b1);
    do_run(2, 1, 1'b0, 1'b1, dc, eb);
    check("rst_no_done", 32'(dc), 32'hFFFF_FFFF);
    gen_pat(1'b1);
    do_run(1, 1, 1'b0, 1'b0, dc, eb);
    check("after_rst_done_cycle", 32'(dc), 1 + 1 + 2 + DRAIN + 1 + 2 + DRAIN);

    // Random runs.
    for (int r = 0; r < 8; r++) begin
      np = $urandom_range(1, 3);
      ni = $urandom_range(1, 2);
      for (int p = 0; p < 4; p++) begin
        ecnt_tab[p] = CNT_W'($urandom_range(0, 4));
        ucnt_tab[p] = CNT_W'($urandom_range(0, 4));
      end
      gen_pat(1'b0);
      do_run(np, ni, 1'($urandom_range(0, 1)), 1'b0, dc, eb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spmv_phase_ctrl.md
# spmv_phase_ctrl

Phase sequencer for the SpMV processing pipeline. Per iteration it walks every partition through the scatter phase, then walks every partition through the gather phase. For each partition it sets the pipeline's 2-bit `control` mode, admits exactly the configured number of edge or update beats, and waits for the scatter/gather pipeline to drain before moving on. It sits between the partition/stream fetch logic and the processing pipeline, and reports iteration and partition progress to the host-side controller.

## Interface
Parameters:
- `PIPE_DEPTH`, 5: depth of the scatter/gather pipelines being sequenced.
- `PAR_W`, 8: width of the partition index and count.
- `ITER_W`, 8: width of the iteration index and count.
- `CNT_W`, 20: width of the per-partition beat counts.
- `DRAIN_CYC`, `PIPE_DEPTH+2`: cycles held after the last beat (input register + buffer read + pipe).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `num_par`  in  PAR_W  partitions per phase; sampled on accepted `start`.
- `num_iter`  in  ITER_W  iterations; sampled on accepted `start`.
- `edge_cnt`  in  CNT_W  edge beats of partition `part_idx`; valid while `control==1`.
- `upd_cnt`  in  CNT_W  update beats of partition `part_idx`; valid while `control==2`.
- `edge_valid`  in  1  edge stream beat available.
- `edge_ready`  out  1  edge beat accepted when `edge_valid & edge_ready`.
- `upd_valid`  in  1  update stream beat available.
- `upd_ready`  out  1  update beat accepted when `upd_valid & upd_ready`.
- `control`  out  2  pipeline mode: 0 idle, 1 scatter, 2 gather.
- `pp_input_valid`  out  1  beat-valid to pipeline; equals accepted-beat strobe.
- `part_idx`  out  PAR_W  current partition.
- `iter_idx`  out  ITER_W  current iteration.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the run completes.

## Operation
- States: IDLE, S_LOAD, SCATTER, S_DRAIN, G_LOAD, GATHER, G_DRAIN.
- IDLE: if `start` and `num_par!=0` and `num_iter!=0`, latch both counts, clear `part_idx` and `iter_idx`, go to S_LOAD. If `start` arrives with either count 0, pulse `done` next cycle and stay in IDLE.
- S_LOAD / G_LOAD: sample `edge_cnt` / `upd_cnt` into `remaining`. If 0, skip the partition immediately (see ADVANCE, no drain). Otherwise go to SCATTER / GATHER.
- SCATTER / GATHER: `edge_ready` / `upd_ready` is high. Each accepted beat decrements `remaining`. On the beat where `remaining==1`, load the drain counter with DRAIN_CYC and go to the matching DRAIN state. Stalls (valid low) are unbounded.
- S_DRAIN / G_DRAIN: hold for exactly DRAIN_CYC cycles, then ADVANCE.
- ADVANCE (transition action, not a state):
  - If `part_idx < num_par-1`: increment `part_idx` and re-enter the same phase's LOAD.
  - After the last partition of scatter: set `part_idx`=0 and go to G_LOAD.
  - After the last partition of gather, with `iter_idx < num_iter-1`: increment `iter_idx`, set `part_idx`=0, go to S_LOAD.
  - Otherwise: go to IDLE and pulse `done`.
- `control` is 1 in S_LOAD, SCATTER and S_DRAIN, 2 in G_LOAD, GATHER and G_DRAIN, and 0 in IDLE.
- Ready signals are low in every state other than SCATTER / GATHER. The opposite stream's ready is always low.
- `start` is ignored while `busy`.

## Timing
- Reset values: state IDLE; `control` = 0; `edge_ready` = `upd_ready` = `pp_input_valid` = 0; `part_idx` = 0; `iter_idx` = 0; `busy` = 0; `done` = 0. Counters reset to 0.
- Reset mid-run aborts immediately with no `done` pulse.
- All outputs are registered, except that ready is decoded from state and `pp_input_valid` = valid & ready. A beat is accepted in the same cycle it is offered.
- `start` sampled at cycle 0 puts S_LOAD in cycle 1 and the first acceptance no earlier than cycle 2.
- Zero-count partition: occupies one LOAD cycle.
- `done` is asserted in the first IDLE cycle, with `busy` = 0 in that cycle.

## Test plan
- Basic run: `num_par`=1, `num_iter`=1, `edge_cnt`=3, `upd_cnt`=2, streams always valid, PIPE_DEPTH=5, `start` at cycle 0 -> S_LOAD c1; edges accepted c2–c4; S_DRAIN c5–c11; G_LOAD c12; updates c13–c14; G_DRAIN c15–c21; `done` at c22.
- Backpressure: `edge_valid` toggles 1,0,1,0,1 -> exactly 3 `pp_input_valid` pulses, coincident with valid-high cycles; drain starts after the 3rd.
- Multi-partition/iteration: `num_par`=3, `num_iter`=2 -> sequence S0,S1,S2,G0,G1,G2 repeated twice; `iter_idx` goes 0→1 on entering the second S_LOAD; single `done`.
- Zero counts: partition 1 with `edge_cnt`=0 -> one S_LOAD cycle, no ready, no drain. `start` with `num_par`=0 -> `done` next cycle, `busy` never high.
- Ignored start / reset: `start` pulsed during GATHER -> no effect. `rst` asserted during S_DRAIN -> all outputs at reset values same cycle, no `done`; a fresh `start` afterward runs normally.
